// File: rtl/psimd_sqrt_seq.sv
// Sequential packed-SIMD square root: feeds four DLfloat16 lanes one at a time through a shared sqrt unit.
// Define PSIMD_SQRT_SEQ_SKIP_EN to visit only enabled lanes instead of all four.
module psimd_sqrt_seq #(
  parameter logic [3:0] SQRT_ENA_CODE = 4'b0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_op,
  input  logic [3:0]  in_mask,
  output logic [3:0]  sqrt_ena,
  output logic [15:0] sqrt_in,
  input  logic [19:0] sqrt_out,
  input  logic [4:0]  sqrt_exc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_res,
  output logic [4:0]  out_exc
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_next;
  logic [63:0] op_q, res_q;
  logic [3:0]  mask_q;
  logic [4:0]  exc_q;
  logic [1:0]  lane, lane_next, first_lane;
  logic        last_lane, lane_en;

  assign lane_en = mask_q[lane];

`ifdef PSIMD_SQRT_SEQ_SKIP_EN
  // Descending scans leave the lowest qualifying lane selected.
  always_comb begin
    first_lane = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (in_mask[i]) first_lane = 2'(i);
    last_lane = 1'b1;
    lane_next = lane;
    for (int i = 3; i >= 0; i--)
      if (i > int'(lane) && mask_q[i]) begin
        last_lane = 1'b0;
        lane_next = 2'(i);
      end
  end
`else
  always_comb begin
    first_lane = 2'd0;
    last_lane  = (lane == 2'd3);
    lane_next  = lane + 2'd1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    sqrt_ena   = 4'b0000;
    sqrt_in    = 16'h0000;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (in_mask == 4'b0000) ? DONE : RUN;
      end
      RUN: begin
        if (lane_en) begin
          sqrt_ena = SQRT_ENA_CODE;
          sqrt_in  = op_q[{lane, 4'b0000} +: 16];
        end
        if (last_lane) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The result register starts as the operand so disabled lanes pass through untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 64'h0;
      mask_q <= 4'h0;
      res_q  <= 64'h0;
      exc_q  <= 5'h0;
      lane   <= 2'd0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q   <= in_op;
          mask_q <= in_mask;
          res_q  <= in_op;
          exc_q  <= 5'h0;
          lane   <= first_lane;
        end
        RUN: begin
          if (lane_en) begin
            res_q[{lane, 4'b0000} +: 16] <= sqrt_out[15:0];
            exc_q <= exc_q | sqrt_exc;
          end
          if (!last_lane) lane <= lane_next;
        end
        default: ;
      endcase
    end
  end

  assign out_res = res_q;
  assign out_exc = exc_q;

endmodule

// File: tb/tb_psimd_sqrt_seq.sv
// Directed bench for psimd_sqrt_seq with a combinational sqrt stub (result = operand + 1, sign raises bit 4).
module tb_psimd_sqrt_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_op = 64'h0;
  logic [3:0]  in_mask = 4'h0;
  logic [3:0]  sqrt_ena;
  logic [15:0] sqrt_in;
  logic [19:0] sqrt_out;
  logic [4:0]  sqrt_exc;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_res;
  logic [4:0]  out_exc;

  int checks = 0;
  int errors = 0;

`ifdef PSIMD_SQRT_SEQ_SKIP_EN
  localparam int LAT_ONE_LANE = 2;
`else
  localparam int LAT_ONE_LANE = 5;
`endif

  always #5 clk = ~clk;

  assign sqrt_out = {4'hA, sqrt_in + 16'h0001};
  assign sqrt_exc = sqrt_in[15] ? 5'b10000 : 5'b00000;

  psimd_sqrt_seq #(.SQRT_ENA_CODE(4'b0100)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_mask(in_mask), .sqrt_ena(sqrt_ena), .sqrt_in(sqrt_in),
    .sqrt_out(sqrt_out), .sqrt_exc(sqrt_exc), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_exc(out_exc)
  );

  // Issues one request, scrambles inputs after capture, and returns the edge count to out_valid.
  task automatic send_and_wait(input logic [63:0] op, input logic [3:0] mask,
                               output int lat, output logic ena_seen);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    in_op = op; in_mask = mask; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 64'hFFFF_FFFF_FFFF_FFFF; in_mask = 4'hF;
    lat = 1;
    ena_seen = (sqrt_ena !== 4'b0000);
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (sqrt_ena !== 4'b0000 && out_valid !== 1'b1) ena_seen = 1'b1;
    end
  endtask

  task automatic consume();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_idle: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_res !== 64'h0 || out_exc !== 5'h0 ||
        sqrt_ena !== 4'h0 || sqrt_in !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: rdy=%b vld=%b res=%h exc=%b ena=%b in=%h", in_ready, out_valid,
               out_res, out_exc, sqrt_ena, sqrt_in);
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_full_mask();
    int lat; logic ena;
    @(negedge clk);
    in_op = 64'h4480_4100_3e00_0000; in_mask = 4'hF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 64'h0; in_mask = 4'h0;
    checks++;
    if (sqrt_ena !== 4'b0100 || sqrt_in !== 16'h0000 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL run_lane0: ena=%b in=%h rdy=%b required 0100/0000/0", sqrt_ena, sqrt_in, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (sqrt_ena !== 4'b0100 || sqrt_in !== 16'h3e00) begin
      errors++;
      $display("[TB] FAIL run_lane1: ena=%b in=%h required 0100/3e00", sqrt_ena, sqrt_in);
    end
    lat = 2;
    while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 5) begin
      errors++;
      $display("[TB] FAIL full_latency: got %0d required 5", lat);
    end
    checks++;
    if (out_res !== 64'h4481_4101_3e01_0001 || out_exc !== 5'h0) begin
      errors++;
      $display("[TB] FAIL full_result: res=%h exc=%b required 448141013e010001/00000", out_res, out_exc);
    end
    consume();
    ena = 1'b0;
  endtask

  task automatic test_single_lane();
    int lat; logic ena;
    send_and_wait(64'h4480_C440_3e00_4200, 4'b0100, lat, ena);
    checks++;
    if (lat != LAT_ONE_LANE) begin
      errors++;
      $display("[TB] FAIL single_latency: got %0d required %0d", lat, LAT_ONE_LANE);
    end
    checks++;
    if (out_res !== 64'h4480_C441_3e00_4200 || out_exc !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL single_result: res=%h exc=%b required 4480c4413e004200/10000", out_res, out_exc);
    end
    consume();
  endtask

  task automatic test_zero_mask();
    int lat; logic ena;
    send_and_wait(64'h1234_5678_9ABC_DEF0, 4'h0, lat, ena);
    checks++;
    if (lat != 1 || ena !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_latency: lat=%0d ena_seen=%b required 1/0", lat, ena);
    end
    checks++;
    if (out_res !== 64'h1234_5678_9ABC_DEF0 || out_exc !== 5'h0) begin
      errors++;
      $display("[TB] FAIL zero_result: res=%h exc=%b required 123456789abcdef0/00000", out_res, out_exc);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat; logic ena;
    send_and_wait(64'h8000_0001_0002_0003, 4'b1001, lat, ena);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_res !== 64'h8001_0001_0002_0004 ||
          out_exc !== 5'b10000) begin
        errors++;
        $display("[TB] FAIL hold_%0d: vld=%b rdy=%b res=%h exc=%b required 1/0/8001000100020004/10000",
                 c, out_valid, in_ready, out_res, out_exc);
      end
    end
    consume();
  endtask

  task automatic test_reset_mid_run();
    int lat; logic ena;
    logic seen_valid = 1'b0;
    @(negedge clk);
    in_op = 64'h4480_4100_3e00_0000; in_mask = 4'hF; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (sqrt_ena !== 4'b0100 || sqrt_in !== 16'h4100) begin
      errors++;
      $display("[TB] FAIL run_lane2: ena=%b in=%h required 0100/4100", sqrt_ena, sqrt_in);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_res !== 64'h0 || out_exc !== 5'h0 ||
        sqrt_ena !== 4'h0 || sqrt_in !== 16'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: rdy=%b vld=%b res=%h exc=%b ena=%b in=%h", in_ready, out_valid,
               out_res, out_exc, sqrt_ena, sqrt_in);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_valid_after_reset: out_valid seen=%b required 0", seen_valid);
    end
    send_and_wait(64'h0010_0020_0030_0040, 4'b0011, lat, ena);
    checks++;
    if (out_res !== 64'h0010_0020_0031_0041 || out_exc !== 5'h0) begin
      errors++;
      $display("[TB] FAIL post_reset_result: res=%h exc=%b required 0010002000310041/00000", out_res, out_exc);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_op = 64'h8000_0001_0002_0003; in_mask = 4'hF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_op = 64'h0100_0200_0300_0400; in_mask = 4'b1010;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (out_res !== 64'h8001_0002_0003_0004 || out_exc !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL b2b_first: res=%h exc=%b required 8001000200030004/10000", out_res, out_exc);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle: rdy=%b vld=%b required 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second_accept: in_ready=%b required 0", in_ready);
    end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (out_res !== 64'h0101_0200_0301_0400 || out_exc !== 5'h0 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_second: vld=%b res=%h exc=%b required 1/0101020003010400/00000",
               out_valid, out_res, out_exc);
    end
    @(negedge clk); out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_single_lane();
    test_zero_mask();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
